// File: rtl/serial_frame_responder.sv
// Target-side endpoint of the serial command frame link: captures an MSB-first
// command word, then returns an MSB-first response word, all in the i_clk domain.
module serial_frame_responder #(
    parameter int CMD_W = 8,
    parameter int RSP_W = 9,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cs_n,
    input  logic             i_sclk,
    input  logic             i_sdi,
    output logic             o_sdo,
    output logic             o_sdoEn,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_cmdValid,
    input  logic [RSP_W-1:0] i_rspData,
    output logic             o_frameDone,
    output logic             o_frameErr,
    output logic             o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(RSP_W - 1);

    logic [1:0]       state;
    logic             sclkQ;
    logic             csnQ;
    logic [CNT_W-1:0] cnt;
    logic [CMD_W-1:0] cmdSr;
    logic [RSP_W-1:0] rspSr;
    logic             loadPend;
    logic             firstFall;
    logic             extraRise;
    logic             sdoEn;

    logic rise;
    logic fall;
    logic csFall;
    logic csRise;

    assign rise   = i_sclk & ~sclkQ;
    assign fall   = ~i_sclk & sclkQ;
    assign csFall = ~i_cs_n & csnQ;
    assign csRise = i_cs_n & ~csnQ;

    assign o_sdoEn = sdoEn;
    assign o_sdo   = sdoEn & rspSr[RSP_W-1];
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            sclkQ       <= 1'b1;
            csnQ        <= 1'b0;
            cnt         <= '0;
            cmdSr       <= '0;
            rspSr       <= '0;
            loadPend    <= 1'b0;
            firstFall   <= 1'b0;
            extraRise   <= 1'b0;
            sdoEn       <= 1'b0;
            o_cmd       <= '0;
            o_cmdValid  <= 1'b0;
            o_frameDone <= 1'b0;
            o_frameErr  <= 1'b0;
        end else begin
            sclkQ       <= i_sclk;
            csnQ        <= i_cs_n;
            o_cmdValid  <= 1'b0;
            o_frameDone <= 1'b0;
            o_frameErr  <= 1'b0;
            loadPend    <= 1'b0;
            case (state)
                IDLE: begin
                    if (csFall) begin
                        state <= CMD;
                        cnt   <= '0;
                    end
                end
                CMD: begin
                    if (csRise) begin
                        state      <= IDLE;
                        o_frameErr <= 1'b1;
                    end else if (rise) begin
                        cmdSr <= {cmdSr[CMD_W-2:0], i_sdi};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CMD_LAST) begin
                            o_cmd      <= {cmdSr[CMD_W-2:0], i_sdi};
                            o_cmdValid <= 1'b1;
                            loadPend   <= 1'b1;
                            firstFall  <= 1'b1;
                            cnt        <= '0;
                            state      <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (csRise) begin
                        state      <= IDLE;
                        o_frameErr <= 1'b1;
                        sdoEn      <= 1'b0;
                    end else begin
                        // First fall belongs to the last command bit: no shift
                        if (loadPend) begin
                            rspSr <= i_rspData;
                            sdoEn <= 1'b1;
                        end else if (fall && !firstFall) begin
                            rspSr <= {rspSr[RSP_W-2:0], 1'b0};
                        end
                        if (fall) begin
                            firstFall <= 1'b0;
                        end
                        if (rise) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == RSP_LAST) begin
                                state     <= DONE;
                                sdoEn     <= 1'b0;
                                extraRise <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (csRise) begin
                        state <= IDLE;
                        if (extraRise) begin
                            o_frameErr <= 1'b1;
                        end else begin
                            o_frameDone <= 1'b1;
                        end
                    end else if (rise) begin
                        extraRise <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_responder.sv
// Directed bench for serial_frame_responder: drives frames as the initiator
// and checks captured commands, returned response bits and frame status pulses.
module tb_serial_frame_responder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cs_n;
    logic       i_sclk;
    logic       i_sdi;
    logic       o_sdo;
    logic       o_sdoEn;
    logic [7:0] o_cmd;
    logic       o_cmdValid;
    logic [8:0] i_rspData;
    logic       o_frameDone;
    logic       o_frameErr;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int vCnt = 0;
    int doneCnt = 0;
    int errCnt = 0;

    serial_frame_responder dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cs_n      (i_cs_n),
        .i_sclk      (i_sclk),
        .i_sdi       (i_sdi),
        .o_sdo       (o_sdo),
        .o_sdoEn     (o_sdoEn),
        .o_cmd       (o_cmd),
        .o_cmdValid  (o_cmdValid),
        .i_rspData   (i_rspData),
        .o_frameDone (o_frameDone),
        .o_frameErr  (o_frameErr),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_cmdValid) vCnt++;
        if (o_frameDone) doneCnt++;
        if (o_frameErr) errCnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startFrame();
        i_cs_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic sendCmd(input logic [7:0] val, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            i_sdi  = val[7-i];
            i_sclk = 1'b1;
            tick();
            i_sclk = 1'b0;
            tick();
        end
    endtask

    task automatic rspClocks(input logic [8:0] exp, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            i_sclk = 1'b1;
            chk({tag, "_sdo"}, 32'(o_sdo), 32'(exp[8-k]));
            chk({tag, "_sdoEn"}, 32'(o_sdoEn), 32'd1);
            tick();
            i_sclk = 1'b0;
            tick();
        end
    endtask

    task automatic endFrame();
        i_cs_n = 1'b1;
        tick();
    endtask

    initial begin
        int v0;
        int d0;
        int e0;
        i_rst     = 1'b1;
        i_cs_n    = 1'b1;
        i_sclk    = 1'b0;
        i_sdi     = 1'b0;
        i_rspData = 9'h000;
        tick();
        tick();
        chk("rst_sdo", 32'(o_sdo), 32'd0);
        chk("rst_sdoEn", 32'(o_sdoEn), 32'd0);
        chk("rst_cmd", 32'(o_cmd), 32'h00);
        chk("rst_cmdValid", 32'(o_cmdValid), 32'd0);
        chk("rst_done", 32'(o_frameDone), 32'd0);
        chk("rst_err", 32'(o_frameErr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        tick();
        tick();
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Frame 1: 0xA5 / 0x1C3
        i_rspData = 9'h1C3;
        startFrame();
        chk("f1_busy", 32'(o_busy), 32'd1);
        sendCmd(8'hA5, 8);
        chk("f1_vcnt", 32'(vCnt), 32'd1);
        chk("f1_cmd", 32'(o_cmd), 32'hA5);
        rspClocks(9'h1C3, 9, "f1");
        chk("f1_sdoEn_off", 32'(o_sdoEn), 32'd0);
        chk("f1_sdo_off", 32'(o_sdo), 32'd0);
        endFrame();
        chk("f1_done", 32'(o_frameDone), 32'd1);
        chk("f1_err", 32'(o_frameErr), 32'd0);
        tick();
        chk("f1_busy_end", 32'(o_busy), 32'd0);
        chk("f1_donecnt", 32'(doneCnt), 32'd1);
        chk("f1_vcnt_end", 32'(vCnt), 32'd1);

        // Back-to-back frames 0x00 and 0xFF
        i_rspData = 9'h0AA;
        startFrame();
        sendCmd(8'h00, 8);
        chk("f2_cmd", 32'(o_cmd), 32'h00);
        rspClocks(9'h0AA, 9, "f2");
        endFrame();
        chk("f2_done", 32'(o_frameDone), 32'd1);
        i_rspData = 9'h155;
        startFrame();
        sendCmd(8'hFF, 8);
        chk("f3_cmd", 32'(o_cmd), 32'hFF);
        rspClocks(9'h155, 9, "f3");
        endFrame();
        chk("f3_done", 32'(o_frameDone), 32'd1);
        tick();
        chk("b2b_vcnt", 32'(vCnt), 32'd3);
        chk("b2b_errcnt", 32'(errCnt), 32'd0);
        chk("b2b_donecnt", 32'(doneCnt), 32'd3);

        // Abort after 5 command bits
        startFrame();
        sendCmd(8'h3B, 5);
        endFrame();
        chk("ab1_err", 32'(o_frameErr), 32'd1);
        chk("ab1_busy", 32'(o_busy), 32'd0);
        tick();
        chk("ab1_errcnt", 32'(errCnt), 32'd1);
        chk("ab1_vcnt", 32'(vCnt), 32'd3);
        chk("ab1_cmd", 32'(o_cmd), 32'hFF);

        // Abort after 4 response bits
        i_rspData = 9'h0F0;
        startFrame();
        sendCmd(8'h5A, 8);
        chk("ab2_cmd", 32'(o_cmd), 32'h5A);
        rspClocks(9'h0F0, 4, "ab2");
        chk("ab2_sdoEn_mid", 32'(o_sdoEn), 32'd1);
        endFrame();
        chk("ab2_err", 32'(o_frameErr), 32'd1);
        chk("ab2_sdoEn", 32'(o_sdoEn), 32'd0);
        chk("ab2_done", 32'(o_frameDone), 32'd0);
        tick();
        chk("ab2_errcnt", 32'(errCnt), 32'd2);

        // Extra 10th rise before cs_n rises
        i_rspData = 9'h101;
        startFrame();
        sendCmd(8'h81, 8);
        rspClocks(9'h101, 9, "ex");
        i_sclk = 1'b1;
        tick();
        i_sclk = 1'b0;
        tick();
        endFrame();
        chk("ex_err", 32'(o_frameErr), 32'd1);
        chk("ex_done", 32'(o_frameDone), 32'd0);
        tick();
        chk("ex_donecnt", 32'(doneCnt), 32'd3);

        // Reset mid-command, rest of frame ignored
        v0 = vCnt;
        d0 = doneCnt;
        e0 = errCnt;
        startFrame();
        sendCmd(8'hC3, 3);
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rr_busy", 32'(o_busy), 32'd0);
        chk("rr_cmd", 32'(o_cmd), 32'h00);
        sendCmd(8'h18, 5);
        for (int k = 0; k < 9; k++) begin
            i_sclk = 1'b1;
            tick();
            i_sclk = 1'b0;
            tick();
        end
        chk("rr_busy2", 32'(o_busy), 32'd0);
        chk("rr_sdoEn", 32'(o_sdoEn), 32'd0);
        endFrame();
        tick();
        chk("rr_vcnt", 32'(vCnt), 32'(v0));
        chk("rr_donecnt", 32'(doneCnt), 32'(d0));
        chk("rr_errcnt", 32'(errCnt), 32'(e0));
        i_rspData = 9'h0C5;
        startFrame();
        sendCmd(8'h3C, 8);
        chk("rr_cmd3c", 32'(o_cmd), 32'h3C);
        rspClocks(9'h0C5, 9, "rr");
        endFrame();
        chk("rr_done", 32'(o_frameDone), 32'd1);
        tick();
        chk("rr_vcnt2", 32'(vCnt), 32'(v0 + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
